// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and
// starvation counter width.
package fullsend_pkg;

    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        DRAIN
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating starvation counter: clear has priority over increment, and the
// count sticks at LIMIT until cleared.
module arb_starve_counter
    import fullsend_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Define MEM_ARB_PERF_EN to add the grant performance counters.
module mem_port_arbiter
    import fullsend_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        flush,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_dm_grants,
    output logic [31:0] perf_forced_grants
`endif
);

    arb_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;

    logic at_limit;
    logic fetch_grant;
    logic data_grant;
    logic starve_inc;

    assign fetch_grant = (state_q == IDLE) && if_req && (!dm_req || at_limit);
    assign data_grant  = (state_q == IDLE) && !fetch_grant && dm_req;
    assign starve_inc  = if_req && !if_valid_q && ((state_q == DATA) || data_grant);

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (reset),
        .inc     (starve_inc),
        .clr     (fetch_grant || flush),
        .at_limit(at_limit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_grant) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end else if (data_grant) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end
            end
            FETCH: begin
                // A flush coinciding with the ack simply drops the returned word.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!flush) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_stall  = if_req && !if_valid_q;
    assign dm_stall  = dm_req && !dm_valid_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_dm_q, perf_forced_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_q     <= '0;
            perf_dm_q     <= '0;
            perf_forced_q <= '0;
        end else begin
            if (fetch_grant) perf_if_q <= perf_if_q + 32'd1;
            if (data_grant) perf_dm_q <= perf_dm_q + 32'd1;
            if (fetch_grant && dm_req && at_limit) perf_forced_q <= perf_forced_q + 32'd1;
        end
    end

    assign perf_if_grants     = perf_if_q;
    assign perf_dm_grants     = perf_dm_q;
    assign perf_forced_grants = perf_forced_q;
`endif

endmodule
